// File: rtl/stamp_stream_source_pkg.sv
// Shared definitions for the stamp replay source.
//   state_t    : control FSM encoding
//   beat_tag_t : per-pixel side-band carried alongside the RAM word
//   C_DIM_WIDTH / C_ADDR_WIDTH : default geometry; PROD_W is the X*Y product width
package stamp_stream_source_pkg;

  localparam int C_DIM_WIDTH  = 10;
  localparam int C_ADDR_WIDTH = 13;
  localparam int PROD_W       = 20;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    STREAM,
    FINISH,
    HOLD
  } state_t;

  typedef struct packed {
    logic last;   // last column of a row -> TLAST
    logic first;  // pixel 0 of the frame  -> TUSER
  } beat_tag_t;

endpackage

// File: rtl/stamp_stream_source_axis_skid2.sv
// Two-entry tagged FIFO feeding the AXI-Stream outputs.
//   push/push_data : RAM return (the producer never pushes when full)
//   pop            : head accepted downstream (valid & ready)
//   valid/head     : head entry, zeroed while empty
//   count          : occupancy 0..2, used by the producer for read credit
module axis_skid2 #(
  parameter int W = 34
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         valid,
  output logic [W-1:0] head,
  output logic [1:0]   count
);

  logic [1:0][W-1:0] mem;
  logic              wr_ptr;
  logic              rd_ptr;

  // The head slot is never written while occupied, so head stays stable
  // through any number of stall cycles.
  always_ff @(posedge clock) begin
    if (reset) begin
      mem    <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: ;
      endcase
    end
  end

  assign valid = (count != 2'd0);
  assign head  = valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/stamp_stream_source.sv
// AXI4-Stream master replaying a stamp image, row-major, from a
// 1-cycle-latency synchronous RAM. TLAST marks the end of each row, TUSER
// marks pixel 0 of the frame.
//   clock, reset       : single clock, synchronous active-high reset
//   GO, X_SIZE, Y_SIZE : frame start (level) and geometry, latched in IDLE
//   DONE, ERROR        : end-of-frame pulse, sticky illegal-size flag
//   rd_en/rd_addr/rd_data : pixel RAM read port
//   M_AXIS_*           : stream master
module stamp_stream_source #(
  parameter int C_M_AXIS_TDATA_WIDTH = 32,
  parameter int C_DIM_WIDTH          = stamp_stream_source_pkg::C_DIM_WIDTH,
  parameter int C_ADDR_WIDTH         = stamp_stream_source_pkg::C_ADDR_WIDTH
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              GO,
  input  logic [C_DIM_WIDTH-1:0]            X_SIZE,
  input  logic [C_DIM_WIDTH-1:0]            Y_SIZE,
  output logic                              DONE,
  output logic                              ERROR,
  output logic                              rd_en,
  output logic [C_ADDR_WIDTH-1:0]           rd_addr,
  input  logic [C_M_AXIS_TDATA_WIDTH-1:0]   rd_data,
  output logic                              M_AXIS_TVALID,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]   M_AXIS_TDATA,
  output logic [C_M_AXIS_TDATA_WIDTH/8-1:0] M_AXIS_TSTRB,
  output logic                              M_AXIS_TLAST,
  output logic                              M_AXIS_TUSER,
  input  logic                              M_AXIS_TREADY
);

  import stamp_stream_source_pkg::*;

  localparam int                      PW       = C_M_AXIS_TDATA_WIDTH + $bits(beat_tag_t);
  localparam logic [PROD_W-1:0]       MAX_PIX  = PROD_W'(2 ** C_ADDR_WIDTH);
  localparam logic [C_DIM_WIDTH-1:0]  DIM_ONE  = 1;

  state_t                   state;
  logic [C_DIM_WIDTH-1:0]   x_q, y_q, col;
  logic [PROD_W-1:0]        total;
  logic [C_ADDR_WIDTH:0]    rd_cnt;    // one extra bit so X*Y = 2**C_ADDR_WIDTH is reachable
  logic [C_ADDR_WIDTH:0]    beat_cnt;
  logic                     inflight;
  beat_tag_t                tag_q, hd_tag;
  logic [PW-1:0]            head;
  logic [1:0]               occ;
  logic                     pop, issue, last_beat, illegal;

  assign total   = PROD_W'(x_q) * PROD_W'(y_q);
  assign illegal = (x_q == '0) || (y_q == '0) || (total > MAX_PIX);

  assign pop       = M_AXIS_TVALID & M_AXIS_TREADY;
  assign last_beat = pop && (PROD_W'(beat_cnt) == total - PROD_W'(1));

  // Read credit: buffered + in-flight after this cycle's pop must leave a free
  // slot. Counting the pop lets a fresh read overlap the accepted beat, which
  // is what sustains one beat per cycle; TVALID itself stays registered.
  assign issue = (state == STREAM) && (PROD_W'(rd_cnt) < total) &&
                 ((occ + {1'b0, inflight} - {1'b0, pop}) < 2'd2);

  assign rd_en   = issue;
  assign rd_addr = rd_cnt[C_ADDR_WIDTH-1:0];

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
      col      <= '0;
      rd_cnt   <= '0;
      beat_cnt <= '0;
      inflight <= 1'b0;
      tag_q    <= '0;
      DONE     <= 1'b0;
      ERROR    <= 1'b0;
    end else begin
      DONE     <= 1'b0;
      inflight <= issue;
      if (issue) begin
        tag_q.last  <= (col == x_q - DIM_ONE);
        tag_q.first <= (rd_cnt == '0);
        rd_cnt      <= rd_cnt + 1'b1;
        col         <= (col == x_q - DIM_ONE) ? '0 : col + DIM_ONE;
      end
      if (pop) beat_cnt <= beat_cnt + 1'b1;

      case (state)
        IDLE: if (GO) begin
          x_q   <= X_SIZE;
          y_q   <= Y_SIZE;
          state <= CHECK;
        end
        CHECK: begin
          rd_cnt   <= '0;
          beat_cnt <= '0;
          col      <= '0;
          ERROR    <= illegal;
          state    <= illegal ? HOLD : STREAM;
        end
        STREAM: if (last_beat) begin
          DONE  <= 1'b1;
          state <= FINISH;
        end
        FINISH: state <= HOLD;
        HOLD:   if (!GO) state <= IDLE;  // no auto-restart while GO stays high
        default: state <= IDLE;
      endcase
    end
  end

  axis_skid2 #(.W(PW)) u_skid (
    .clock     (clock),
    .reset     (reset),
    .push      (inflight),
    .push_data ({rd_data, tag_q}),
    .pop       (pop),
    .valid     (M_AXIS_TVALID),
    .head      (head),
    .count     (occ)
  );

  assign hd_tag        = beat_tag_t'(head[$bits(beat_tag_t)-1:0]);
  assign M_AXIS_TDATA  = head[PW-1 -: C_M_AXIS_TDATA_WIDTH];
  assign M_AXIS_TLAST  = hd_tag.last;
  assign M_AXIS_TUSER  = hd_tag.first;
  assign M_AXIS_TSTRB  = {(C_M_AXIS_TDATA_WIDTH/8){M_AXIS_TVALID}};

endmodule

// File: tb/tb_stamp_stream_source.sv
module tb_stamp_stream_source;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        GO = 1'b0;
  logic [9:0]  X_SIZE = '0, Y_SIZE = '0;
  logic        DONE, ERROR, rd_en;
  logic [12:0] rd_addr;
  logic [31:0] rd_data = '0;
  logic        M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TUSER;
  logic [31:0] M_AXIS_TDATA;
  logic [3:0]  M_AXIS_TSTRB;
  logic        M_AXIS_TREADY = 1'b1;

  stamp_stream_source dut (
    .clock(clock), .reset(reset), .GO(GO), .X_SIZE(X_SIZE), .Y_SIZE(Y_SIZE),
    .DONE(DONE), .ERROR(ERROR), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .M_AXIS_TVALID(M_AXIS_TVALID), .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TSTRB(M_AXIS_TSTRB),
    .M_AXIS_TLAST(M_AXIS_TLAST), .M_AXIS_TUSER(M_AXIS_TUSER), .M_AXIS_TREADY(M_AXIS_TREADY)
  );

  initial forever #5 clock = ~clock;

  // Pixel RAM model, one cycle read latency
  logic [31:0] ram [0:8191];
  always @(posedge clock) if (rd_en) rd_data <= ram[rd_addr];

  int cyc = 0;
  always @(posedge clock) cyc++;

  // Sink ready pattern: 0 = always ready, 1 = toggle, 2 = random
  int rdy_mode = 0;
  always @(posedge clock) begin
    #1;
    case (rdy_mode)
      0:       M_AXIS_TREADY = 1'b1;
      1:       M_AXIS_TREADY = ~M_AXIS_TREADY;
      default: M_AXIS_TREADY = 1'($urandom_range(0, 1));
    endcase
  end

  // Observation of the stream, sampled mid-cycle
  logic [33:0] cap [$];
  logic [33:0] held;
  logic        hold_pend = 1'b0, prev_err = 1'b0;
  int go_cyc, done_cnt, done_cyc, first_vld_cyc, first_hs_cyc, last_hs_cyc;
  int vld_cycles, stab_viol, strb_viol, err_rise_cyc, rd_issues, max_rd_addr;

  always @(negedge clock) begin
    if (!reset) begin
      if (M_AXIS_TSTRB !== {4{M_AXIS_TVALID}}) strb_viol++;
      if (hold_pend && (M_AXIS_TVALID !== 1'b1 ||
          {M_AXIS_TDATA, M_AXIS_TLAST, M_AXIS_TUSER} !== held)) stab_viol++;
      hold_pend = M_AXIS_TVALID && !M_AXIS_TREADY;
      held      = {M_AXIS_TDATA, M_AXIS_TLAST, M_AXIS_TUSER};
      if (M_AXIS_TVALID) begin
        vld_cycles++;
        if (first_vld_cyc < 0) first_vld_cyc = cyc;
      end
      if (M_AXIS_TVALID && M_AXIS_TREADY) begin
        cap.push_back({M_AXIS_TDATA, M_AXIS_TLAST, M_AXIS_TUSER});
        if (first_hs_cyc < 0) first_hs_cyc = cyc;
        last_hs_cyc = cyc;
      end
      if (DONE) begin done_cnt++; done_cyc = cyc; end
      if (ERROR && !prev_err) err_rise_cyc = cyc;
      prev_err = ERROR;
      if (rd_en) begin
        rd_issues++;
        if (int'(rd_addr) > max_rd_addr) max_rd_addr = int'(rd_addr);
      end
    end else begin
      hold_pend = 1'b0;
      prev_err  = 1'b0;
    end
  end

  int n_checks = 0, n_pass = 0;

  // Reference: beat i of a frame X wide carries ram[i], TLAST at the row end,
  // TUSER only on pixel 0.
  function automatic logic [33:0] exp_beat(input int x, input int i);
    logic lst, fst;
    lst = ((i % x) == (x - 1));
    fst = (i == 0);
    return {ram[i], lst, fst};
  endfunction

  task automatic fill_ram(input bit ident);
    for (int i = 0; i < 8192; i++) ram[i] = ident ? 32'(i) : $urandom;
  endtask

  task automatic clear_mon();
    cap.delete();
    done_cnt = 0; done_cyc = -1; first_vld_cyc = -1; first_hs_cyc = -1; last_hs_cyc = -1;
    vld_cycles = 0; stab_viol = 0; strb_viol = 0; err_rise_cyc = -1;
    rd_issues = 0; max_rd_addr = -1;
  endtask

  task automatic start_frame(input int x, input int y, input bit hold);
    clear_mon();
    @(posedge clock); #1;
    X_SIZE = 10'(x); Y_SIZE = 10'(y); GO = 1'b1; go_cyc = cyc;
    if (!hold) begin @(posedge clock); #1; GO = 1'b0; end
  endtask

  task automatic wait_done(input int max_cyc, output bit timed_out);
    timed_out = 1'b1;
    for (int k = 0; k < max_cyc; k++) begin
      @(posedge clock);
      if (done_cnt != 0) begin timed_out = 1'b0; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; GO = 1'b1; X_SIZE = 10'd8; Y_SIZE = 10'd8;
    repeat (4) @(posedge clock);
    @(negedge clock);
    n_checks++;
    if ({M_AXIS_TVALID, DONE, ERROR, rd_en, M_AXIS_TLAST, M_AXIS_TUSER} !== 6'b0)
      $display("FAIL reset_ctrl got=%b exp=000000",
               {M_AXIS_TVALID, DONE, ERROR, rd_en, M_AXIS_TLAST, M_AXIS_TUSER});
    else n_pass++;
    n_checks++;
    if (M_AXIS_TDATA !== 32'd0 || M_AXIS_TSTRB !== 4'd0 || rd_addr !== 13'd0)
      $display("FAIL reset_data got tdata=%h tstrb=%h rd_addr=%0d exp 0/0/0",
               M_AXIS_TDATA, M_AXIS_TSTRB, rd_addr);
    else n_pass++;
    @(posedge clock); #1; reset = 1'b0; GO = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    n_checks++;
    if (M_AXIS_TVALID !== 1'b0 || rd_en !== 1'b0)
      $display("FAIL reset_idle got tvalid=%b rd_en=%b exp 0/0", M_AXIS_TVALID, rd_en);
    else n_pass++;
  endtask

  task automatic test_basic_8x8();
    bit to; int bad;
    fill_ram(1'b1); rdy_mode = 0;
    start_frame(8, 8, 1'b0);
    wait_done(400, to);
    repeat (3) @(posedge clock);
    n_checks++;
    if (to) $display("FAIL t1_timeout got=no DONE exp=DONE"); else n_pass++;
    bad = -1;
    foreach (cap[i]) if (i >= 64 || cap[i] !== exp_beat(8, i)) begin if (bad < 0) bad = i; end
    n_checks++;
    if (cap.size() != 64 || bad >= 0)
      $display("FAIL t1_beats got size=%0d first_bad=%0d exp size=64 first_bad=-1", cap.size(), bad);
    else n_pass++;
    n_checks++;
    if (first_vld_cyc - go_cyc != 4)
      $display("FAIL t1_latency got=%0d exp=4", first_vld_cyc - go_cyc);
    else n_pass++;
    n_checks++;
    if (last_hs_cyc - first_hs_cyc != 63)
      $display("FAIL t1_throughput got=%0d exp=63", last_hs_cyc - first_hs_cyc);
    else n_pass++;
    n_checks++;
    if (done_cnt != 1 || done_cyc != last_hs_cyc + 1)
      $display("FAIL t1_done got cnt=%0d cyc=%0d exp cnt=1 cyc=%0d", done_cnt, done_cyc, last_hs_cyc + 1);
    else n_pass++;
    n_checks++;
    if (strb_viol != 0) $display("FAIL t1_tstrb got=%0d exp=0", strb_viol); else n_pass++;
  endtask

  task automatic test_toggle_5x5();
    bit to; int bad;
    fill_ram(1'b0); rdy_mode = 1;
    start_frame(5, 5, 1'b0);
    wait_done(400, to);
    repeat (3) @(posedge clock);
    n_checks++;
    if (to) $display("FAIL t2_timeout got=no DONE exp=DONE"); else n_pass++;
    bad = -1;
    foreach (cap[i]) if (i >= 25 || cap[i] !== exp_beat(5, i)) begin if (bad < 0) bad = i; end
    n_checks++;
    if (cap.size() != 25 || bad >= 0)
      $display("FAIL t2_beats got size=%0d first_bad=%0d exp size=25 first_bad=-1", cap.size(), bad);
    else n_pass++;
    n_checks++;
    if (stab_viol != 0) $display("FAIL t2_stable got=%0d exp=0", stab_viol); else n_pass++;
    n_checks++;
    if (vld_cycles <= 25) $display("FAIL t2_stalls got=%0d exp>25", vld_cycles); else n_pass++;
    n_checks++;
    if (done_cnt != 1) $display("FAIL t2_done got=%0d exp=1", done_cnt); else n_pass++;
    rdy_mode = 0;
  endtask

  task automatic test_error_small();
    bit to;
    fill_ram(1'b0); rdy_mode = 0;
    start_frame(0, 4, 1'b0);
    repeat (12) @(posedge clock);
    n_checks++;
    if (ERROR !== 1'b1 || err_rise_cyc != go_cyc + 2)
      $display("FAIL t3_error got err=%b rise=%0d exp err=1 rise=%0d", ERROR, err_rise_cyc, go_cyc + 2);
    else n_pass++;
    n_checks++;
    if (vld_cycles != 0 || done_cnt != 0 || rd_issues != 0)
      $display("FAIL t3_quiet got vld=%0d done=%0d rd=%0d exp 0/0/0", vld_cycles, done_cnt, rd_issues);
    else n_pass++;
    start_frame(1, 1, 1'b0);
    wait_done(100, to);
    repeat (2) @(posedge clock);
    n_checks++;
    if (to || ERROR !== 1'b0)
      $display("FAIL t3_clear got timeout=%0d err=%b exp 0/0", to, ERROR);
    else n_pass++;
    n_checks++;
    if (cap.size() != 1 || cap[0] !== {ram[0], 1'b1, 1'b1})
      $display("FAIL t3_single got size=%0d exp size=1 beat=%h", cap.size(), {ram[0], 2'b11});
    else n_pass++;
  endtask

  task automatic test_max_frame();
    bit to; int bad;
    fill_ram(1'b0); rdy_mode = 0;
    start_frame(128, 65, 1'b0);
    repeat (12) @(posedge clock);
    n_checks++;
    if (ERROR !== 1'b1 || err_rise_cyc != go_cyc + 2 || vld_cycles != 0)
      $display("FAIL t4_oversize got err=%b rise=%0d vld=%0d exp 1/%0d/0", ERROR, err_rise_cyc, vld_cycles, go_cyc + 2);
    else n_pass++;
    start_frame(128, 64, 1'b0);
    wait_done(9000, to);
    repeat (3) @(posedge clock);
    n_checks++;
    if (to || ERROR !== 1'b0) $display("FAIL t4_timeout got timeout=%0d err=%b exp 0/0", to, ERROR); else n_pass++;
    bad = -1;
    foreach (cap[i]) if (i >= 8192 || cap[i] !== exp_beat(128, i)) begin if (bad < 0) bad = i; end
    n_checks++;
    if (cap.size() != 8192 || bad >= 0)
      $display("FAIL t4_beats got size=%0d first_bad=%0d exp size=8192 first_bad=-1", cap.size(), bad);
    else n_pass++;
    n_checks++;
    if (max_rd_addr != 8191 || rd_issues != 8192)
      $display("FAIL t4_addr got max=%0d reads=%0d exp 8191/8192", max_rd_addr, rd_issues);
    else n_pass++;
  endtask

  task automatic test_reset_midframe();
    bit to, reached; int bad;
    fill_ram(1'b0); rdy_mode = 0;
    start_frame(8, 8, 1'b0);
    reached = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clock);
      if (cap.size() >= 10) begin reached = 1'b1; break; end
    end
    n_checks++;
    if (!reached) $display("FAIL t5_reach got=%0d beats exp>=10", cap.size()); else n_pass++;
    #1; reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    n_checks++;
    if (M_AXIS_TVALID !== 1'b0 || DONE !== 1'b0)
      $display("FAIL t5_abort got tvalid=%b done=%b exp 0/0", M_AXIS_TVALID, DONE);
    else n_pass++;
    @(posedge clock); #1; reset = 1'b0;
    repeat (20) @(posedge clock);
    n_checks++;
    if (done_cnt != 0 || vld_cycles > 12)
      $display("FAIL t5_nodone got done=%0d vld=%0d exp done=0 vld<=12", done_cnt, vld_cycles);
    else n_pass++;
    start_frame(8, 8, 1'b0);
    wait_done(400, to);
    repeat (2) @(posedge clock);
    bad = -1;
    foreach (cap[i]) if (i >= 64 || cap[i] !== exp_beat(8, i)) begin if (bad < 0) bad = i; end
    n_checks++;
    if (to || cap.size() != 64 || bad >= 0)
      $display("FAIL t5_restart got timeout=%0d size=%0d first_bad=%0d exp 0/64/-1", to, cap.size(), bad);
    else n_pass++;
  endtask

  task automatic test_go_hold();
    bit to; int bad;
    fill_ram(1'b0); rdy_mode = 0;
    start_frame(3, 2, 1'b1);
    wait_done(200, to);
    repeat (20) @(posedge clock);
    n_checks++;
    if (to || done_cnt != 1 || cap.size() != 6 || rd_issues != 6)
      $display("FAIL t6_hold got timeout=%0d done=%0d beats=%0d reads=%0d exp 0/1/6/6",
               to, done_cnt, cap.size(), rd_issues);
    else n_pass++;
    #1; GO = 1'b0;
    repeat (3) @(posedge clock);
    start_frame(3, 2, 1'b0);
    wait_done(200, to);
    repeat (2) @(posedge clock);
    bad = -1;
    foreach (cap[i]) if (i >= 6 || cap[i] !== exp_beat(3, i)) begin if (bad < 0) bad = i; end
    n_checks++;
    if (to || done_cnt != 1 || cap.size() != 6 || bad >= 0)
      $display("FAIL t6_rearm got timeout=%0d done=%0d size=%0d first_bad=%0d exp 0/1/6/-1",
               to, done_cnt, cap.size(), bad);
    else n_pass++;
  endtask

  task automatic test_random();
    bit to; int bad, x, y, n;
    for (int f = 0; f < 4; f++) begin
      x = $urandom_range(1, 24); y = $urandom_range(1, 12); n = x * y;
      fill_ram(1'b0); rdy_mode = 2;
      start_frame(x, y, 1'b0);
      wait_done(n * 8 + 100, to);
      repeat (3) @(posedge clock);
      bad = -1;
      foreach (cap[i]) if (i >= n || cap[i] !== exp_beat(x, i)) begin if (bad < 0) bad = i; end
      n_checks++;
      if (to || cap.size() != n || bad >= 0)
        $display("FAIL rnd_beats x=%0d y=%0d got timeout=%0d size=%0d first_bad=%0d exp 0/%0d/-1",
                 x, y, to, cap.size(), bad, n);
      else n_pass++;
      n_checks++;
      if (stab_viol != 0 || done_cnt != 1)
        $display("FAIL rnd_proto x=%0d y=%0d got stab=%0d done=%0d exp 0/1", x, y, stab_viol, done_cnt);
      else n_pass++;
    end
    rdy_mode = 0;
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_basic_8x8();
    test_toggle_5x5();
    test_error_small();
    test_max_frame();
    test_reset_midframe();
    test_go_hold();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
